arisc_mem_host: RTL and testbench

- Memory-side counterpart of the A-RISC cpu.
- Owns the instruction RAM (16-bit words) and the data RAM (W-bit words), and answers the cpu's iram/dram accesses with 1-cycle synchronous reads.
- Exposes a host command/response stream (valid/ready) to load programs and data, run the cpu through its start/idle handshake, and read back results.
- Sits between the testbench or SoC host and one cpu instance.

---
 rtl/arisc_host_pkg.sv | 22 ++
 rtl/sync_ram.sv | 29 ++
 rtl/arisc_mem_host.sv | 167 ++++++++++++++++
 tb/tb_arisc_mem_host.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arisc_host_pkg.sv
// Shared types for the A-RISC memory host: host command opcodes and FSM states.
package arisc_host_pkg;

  localparam int unsigned INSN_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    OP_WR_I = 2'd0,
    OP_WR_D = 2'd1,
    OP_RD_D = 2'd2,
    OP_RUN  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_READY  = 3'd0,
    S_RDWAIT = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_RSP    = 3'd4
  } state_e;

endpackage

// File: rtl/sync_ram.sv
// Single-port RAM: synchronous write, registered read-first output (output register resets to 0).
module sync_ram #(
  parameter int unsigned W_DATA = 16,
  parameter int unsigned W_ADDR = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [W_ADDR-1:0] addr,
  input  logic [W_DATA-1:0] din,
  output logic [W_DATA-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** W_ADDR;

  logic [W_DATA-1:0] mem [DEPTH];

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  // Registered read; sees the pre-write value on a same-address write.
  always_ff @(posedge clk) begin
    if (!rstn) dout <= '0;
    else       dout <= mem[addr];
  end

endmodule

// File: rtl/arisc_mem_host.sv
// A-RISC memory host: owns iram/dram, serves the cpu, and runs a host command/response stream.
// Optional watchdog on RUN enabled by defining ARISC_HOST_TIMEOUT_EN.
module arisc_mem_host
  import arisc_host_pkg::*;
#(
  parameter int unsigned W              = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [W-1:0]      cmd_addr,
  input  logic [INSN_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CNT_W-1:0]  rsp_data,
  output logic              rsp_err,
  output logic              cpu_start,
  input  logic              cpu_idle,
  output logic              cpu_rstn,
  input  logic [W-1:0]      cpu_iram_addr,
  output logic [INSN_W-1:0] cpu_iram_dout,
  input  logic [W-1:0]      cpu_dram_addr,
  input  logic [W-1:0]      cpu_dram_din,
  input  logic              cpu_dram_write,
  output logic [W-1:0]      cpu_dram_dout
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] rsp_data_nxt;
  logic             rsp_err_nxt;
  logic             cpu_rstn_nxt;
  cmd_op_e          op;
  logic             accept;
  logic             cpu_own;
  logic [W-1:0]     iram_addr, dram_addr, dram_din;
  logic             iram_we, dram_we;

  assign op      = cmd_op_e'(cmd_op);
  assign accept  = cmd_valid && cmd_ready;
  assign cpu_own = (state == S_START) || (state == S_RUN);
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  // RAM port ownership: cpu while starting/running, host otherwise.
  always_comb begin
    iram_addr = cmd_addr;
    dram_addr = cmd_addr;
    dram_din  = cmd_data[W-1:0];
    iram_we   = rstn && accept && (op == OP_WR_I);
    dram_we   = rstn && accept && (op == OP_WR_D);
    if (cpu_own) begin
      iram_addr = cpu_iram_addr;
      dram_addr = cpu_dram_addr;
      dram_din  = cpu_dram_din;
      iram_we   = 1'b0;
      dram_we   = rstn && cpu_dram_write;
    end
  end

  sync_ram #(.W_DATA(INSN_W), .W_ADDR(W)) u_iram (
    .clk  (clk),
    .rstn (rstn),
    .we   (iram_we),
    .addr (iram_addr),
    .din  (cmd_data),
    .dout (cpu_iram_dout)
  );

  sync_ram #(.W_DATA(W), .W_ADDR(W)) u_dram (
    .clk  (clk),
    .rstn (rstn),
    .we   (dram_we),
    .addr (dram_addr),
    .din  (dram_din),
    .dout (cpu_dram_dout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_READY;
    else       state <= state_nxt;
  end

  // Next-state and next-output logic; first S_RUN cycle (cnt==0) ignores cpu_idle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rsp_data_nxt = rsp_data;
    rsp_err_nxt  = rsp_err;
    cpu_rstn_nxt = 1'b1;
    case (state)
      S_READY: begin
        if (accept) begin
          case (op)
            OP_RD_D: state_nxt = S_RDWAIT;
            OP_RUN:  state_nxt = S_START;
            default: state_nxt = S_READY;
          endcase
        end
      end
      S_RDWAIT: begin
        rsp_data_nxt = CNT_W'(cpu_dram_dout);
        rsp_err_nxt  = 1'b0;
        state_nxt    = S_RSP;
      end
      S_START: begin
        cnt_nxt   = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        cnt_nxt = cnt_inc;
        if ((cnt != '0) && cpu_idle) begin
          rsp_data_nxt = cnt_inc;
          rsp_err_nxt  = 1'b0;
          state_nxt    = S_RSP;
        end
`ifdef ARISC_HOST_TIMEOUT_EN
        else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          rsp_data_nxt = CNT_W'(TIMEOUT_CYCLES);
          rsp_err_nxt  = 1'b1;
          cpu_rstn_nxt = 1'b0;
          state_nxt    = S_RSP;
        end
`endif
      end
      S_RSP: begin
        if (rsp_ready) state_nxt = S_READY;
      end
      default: state_nxt = S_READY;
    endcase
  end

`ifdef ARISC_HOST_TIMEOUT_EN
  // Watchdog error flag.
  always_ff @(posedge clk) begin
    if (!rstn) rsp_err <= 1'b0;
    else       rsp_err <= rsp_err_nxt;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CYCLES, rsp_err_nxt};
  assign rsp_err        = 1'b0;
`endif

  // Registered outputs and run counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt       <= '0;
      rsp_data  <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      cpu_start <= 1'b0;
      cpu_rstn  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      rsp_data  <= rsp_data_nxt;
      cmd_ready <= (state_nxt == S_READY);
      rsp_valid <= (state_nxt == S_RSP);
      cpu_start <= (state_nxt == S_START);
      cpu_rstn  <= cpu_rstn_nxt;
    end
  end

endmodule

// File: tb/tb_arisc_mem_host.sv
// Directed bench for arisc_mem_host; the cpu side is driven cycle by cycle from the stimulus.
module tb_arisc_mem_host;

  localparam int unsigned W  = 8;
  localparam int unsigned TO = 64;

  localparam logic [1:0] WR_I = 2'd0;
  localparam logic [1:0] WR_D = 2'd1;
  localparam logic [1:0] RD_D = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_addr;
  logic [15:0]   cmd_data;
  logic          rsp_valid, rsp_ready;
  logic [15:0]   rsp_data;
  logic          rsp_err;
  logic          cpu_start, cpu_idle, cpu_rstn;
  logic [W-1:0]  cpu_iram_addr;
  logic [15:0]   cpu_iram_dout;
  logic [W-1:0]  cpu_dram_addr, cpu_dram_din, cpu_dram_dout;
  logic          cpu_dram_write;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  arisc_mem_host #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .cpu_start      (cpu_start),
    .cpu_idle       (cpu_idle),
    .cpu_rstn       (cpu_rstn),
    .cpu_iram_addr  (cpu_iram_addr),
    .cpu_iram_dout  (cpu_iram_dout),
    .cpu_dram_addr  (cpu_dram_addr),
    .cpu_dram_din   (cpu_dram_din),
    .cpu_dram_write (cpu_dram_write),
    .cpu_dram_dout  (cpu_dram_dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Issue one command from a negedge; returns at the negedge after the accept edge.
  task automatic host_cmd(input logic [1:0] op, input logic [W-1:0] addr, input logic [15:0] data);
    chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cyc();
    cmd_valid = 1'b0;
  endtask

  // Called at a negedge where the response must be present; completes the handshake.
  task automatic take_rsp(input string tag, input logic [15:0] exp_data, input logic exp_err);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_data));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready_again"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic read_d(input string tag, input logic [W-1:0] addr, input logic [15:0] exp_data);
    host_cmd(RD_D, addr, 16'h0000);
    chk({tag, "_rdwait_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdwait_ready"}, 32'(cmd_ready), 32'd0);
    cyc();
    take_rsp(tag, exp_data, 1'b0);
  endtask

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0;
    cpu_idle = 1'b1; cpu_iram_addr = '0; cpu_dram_addr = '0; cpu_dram_din = '0; cpu_dram_write = 1'b0;
    op_a = '0; op_b = '0;

    // Reset values
    repeat (3) cyc();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_cpu_start", 32'(cpu_start), 32'd0);
    chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("rst_iram_dout", 32'(cpu_iram_dout), 32'd0);
    chk("rst_dram_dout", 32'(cpu_dram_dout), 32'd0);
    rstn = 1'b1;
    cyc();
    chk("post_rst_cpu_rstn", 32'(cpu_rstn), 32'd1);

    // Data write then read-back
    host_cmd(WR_D, 8'd5, 16'hFF3C);
    read_d("rd5", 8'd5, 16'h003C);

    // RUN with a short program: idle ignored in first run cycle, 3 counted cycles
    host_cmd(WR_I, 8'd0, 16'h0000);
    host_cmd(WR_I, 8'd1, 16'hA5C3);
    cpu_iram_addr = 8'd1;
    host_cmd(RUN, 8'd0, 16'h0000);
    chk("run_start_hi", 32'(cpu_start), 32'd1);
    chk("run_ready_lo", 32'(cmd_ready), 32'd0);
    cyc();
    chk("run_start_pulse", 32'(cpu_start), 32'd0);
    cyc();
    cpu_idle = 1'b0;
    chk("run_fetch", 32'(cpu_iram_dout), 32'hA5C3);
    chk("run_busy1", 32'(rsp_valid), 32'd0);
    cyc();
    cpu_idle = 1'b1;
    chk("run_busy2", 32'(rsp_valid), 32'd0);
    cyc();
    take_rsp("run3", 16'd3, 1'b0);
    cpu_iram_addr = '0;

    // 6*7 stored by the cpu to dram[0x10]
    host_cmd(WR_D, 8'h00, 16'h0006);
    host_cmd(WR_D, 8'h01, 16'h0007);
    host_cmd(RUN, 8'd0, 16'h0000);
    cpu_dram_addr = 8'h00;
    cyc();
    op_a = cpu_dram_dout;
    chk("mul_ld_a", 32'(op_a), 32'd6);
    cpu_dram_addr = 8'h01;
    cyc();
    op_b = cpu_dram_dout;
    chk("mul_ld_b", 32'(op_b), 32'd7);
    cpu_dram_addr  = 8'h10;
    cpu_dram_din   = W'(op_a * op_b);
    cpu_dram_write = 1'b1;
    cpu_idle       = 1'b0;
    cyc();
    cpu_dram_write = 1'b0;
    cpu_idle       = 1'b1;
    cyc();
    take_rsp("mul_run", 16'd3, 1'b0);
    read_d("mul_rd", 8'h10, 16'h002A);

    // Backpressure: response held stable for 10 cycles
    host_cmd(RD_D, 8'h10, 16'h0000);
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'h002A);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      cyc();
    end
    take_rsp("bp", 16'h002A, 1'b0);

    // Same-cycle cpu store and load of one address
    host_cmd(WR_D, 8'h20, 16'h0011);
    host_cmd(RUN, 8'd0, 16'h0000);
    cpu_dram_addr = 8'h20;
    cpu_dram_din  = 8'h99;
    cyc();
    chk("same_pre", 32'(cpu_dram_dout), 32'h11);
    cpu_dram_write = 1'b1;
    cyc();
    chk("same_old", 32'(cpu_dram_dout), 32'h11);
    cpu_dram_write = 1'b0;
    cpu_idle = 1'b0;
    cyc();
    chk("same_new", 32'(cpu_dram_dout), 32'h99);
    cpu_idle = 1'b1;
    cyc();
    take_rsp("same_run", 16'd3, 1'b0);

    // cpu store outside a run is ignored
    cpu_dram_addr  = 8'h20;
    cpu_dram_din   = 8'h55;
    cpu_dram_write = 1'b1;
    cyc();
    cpu_dram_write = 1'b0;
    read_d("ign_wr", 8'h20, 16'h0099);

    // Reset in the middle of a run
    host_cmd(RUN, 8'd0, 16'h0000);
    cyc();
    cpu_idle = 1'b0;
    rstn = 1'b0;
    cyc();
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_cpu_start", 32'(cpu_start), 32'd0);
    chk("midrst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    cpu_idle = 1'b1;
    cyc();
    rstn = 1'b1;
    cyc();
    chk("midrst_release", 32'(cpu_rstn), 32'd1);
    read_d("midrst_rd5", 8'd5, 16'h003C);

`ifdef ARISC_HOST_TIMEOUT_EN
    // Watchdog on a self-looping program
    begin
      int  lows;
      bit  got;
      lows = 0;
      got  = 1'b0;
      host_cmd(WR_I, 8'd0, 16'hC000);
      host_cmd(RUN, 8'd0, 16'h0000);
      cyc();
      cpu_idle = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        cyc();
        if (!cpu_rstn) lows++;
        if (rsp_valid) got = 1'b1;
      end
      chk("to_rsp_seen", 32'(got), 32'd1);
      chk("to_err", 32'(rsp_err), 32'd1);
      chk("to_data", 32'(rsp_data), 32'(TO));
      cyc();
      if (!cpu_rstn) lows++;
      chk("to_cpu_rstn_back", 32'(cpu_rstn), 32'd1);
      chk("to_cpu_rstn_lows", 32'(lows), 32'd1);
      cpu_idle = 1'b1;
      take_rsp("to", 16'(TO), 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
